// File: rtl/panel_pkg.sv
// Shared definitions for the front-panel entry blocks: action codes,
// board-clock repeat timing defaults and a decimal weight helper.
package panel_pkg;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_RIGHT,
    ACT_LEFT,
    ACT_UP,
    ACT_DOWN
  } action_e;

  // 1 s initial hold and 200 ms repeat rate at the 50 MHz board clock
  localparam int unsigned DEF_REPEAT_DELAY  = 50_000_000;
  localparam int unsigned DEF_REPEAT_PERIOD = 10_000_000;

  function automatic logic [63:0] pow10(input int unsigned k);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < k; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/key_conditioner.sv
// One push-button: two-FF synchroniser, registered rising-edge pulse and
// optional hold-to-auto-repeat.
module key_conditioner
  import panel_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic pulse_o
);

  logic        sync1_q, sync2_q, prev_q, pulse_q, pulse_d, rep_hit;
  logic [31:0] cnt_q, cnt_d, per_q, per_d;

  // cnt_q holds the number of cycles the synchronised key has been high,
  // saturating at REPEAT_DELAY; per_q then phases the repeat period.
  always_comb begin
    cnt_d   = '0;
    per_d   = '0;
    rep_hit = 1'b0;
    if (sync2_q) begin
      cnt_d = (cnt_q == REPEAT_DELAY) ? cnt_q : cnt_q + 32'd1;
      if (cnt_q == REPEAT_DELAY) begin
        rep_hit = (REPEAT_DELAY != 0) && (per_q == '0);
        per_d   = (per_q == REPEAT_PERIOD - 1) ? '0 : per_q + 32'd1;
      end
    end
    pulse_d = (sync2_q & ~prev_q) | rep_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
      per_q   <= '0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/digit_field_editor.sv
// Front-panel numeric editor: one-hot digit cursor over NUM_FIELDS decimal
// fields, up/down steps by the selected digit's weight.
module digit_field_editor
  import panel_pkg::*;
#(
  parameter int unsigned NUM_FIELDS       = 2,
  parameter int unsigned DIGITS_PER_FIELD = 2,
  parameter int unsigned VAL_W            = 32,
  parameter int unsigned MAX_VAL          = 99,
  parameter bit          VAL_WRAP         = 1'b0,
  parameter bit          CURSOR_WRAP      = 1'b0,
  parameter int unsigned REPEAT_DELAY     = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD    = DEF_REPEAT_PERIOD
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   up,
  input  logic                                   down,
  input  logic                                   left,
  input  logic                                   right,
  input  logic                                   lock,
  output logic [NUM_FIELDS*VAL_W-1:0]            values,
  output logic [NUM_FIELDS*DIGITS_PER_FIELD-1:0] dotpos_n,
  output logic                                   edit_stb
);

  localparam int unsigned NC = NUM_FIELDS * DIGITS_PER_FIELD;
  localparam int unsigned FW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  typedef logic [VAL_W:0] wide_t;
  localparam wide_t MAXW = wide_t'(MAX_VAL);
  localparam wide_t MODW = wide_t'(MAX_VAL) + wide_t'(1);

  if (64'(MAX_VAL) >= pow10(DIGITS_PER_FIELD)) begin : g_chk_digits
    $fatal(1, "MAX_VAL does not fit in DIGITS_PER_FIELD decimal digits");
  end
  if (VAL_W < 64 && 64'(MAX_VAL) >= (64'd1 << VAL_W)) begin : g_chk_width
    $fatal(1, "MAX_VAL does not fit in VAL_W bits");
  end

  logic [3:0] pulse;  // 0 up, 1 down, 2 left, 3 right

  key_conditioner #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_key_up    (.clk(clk), .rst_n(rst_n), .key_i(up),    .pulse_o(pulse[0]));
  key_conditioner #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_key_down  (.clk(clk), .rst_n(rst_n), .key_i(down),  .pulse_o(pulse[1]));
  key_conditioner #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_key_left  (.clk(clk), .rst_n(rst_n), .key_i(left),  .pulse_o(pulse[2]));
  key_conditioner #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_key_right (.clk(clk), .rst_n(rst_n), .key_i(right), .pulse_o(pulse[3]));

  logic [VAL_W-1:0] vals_q [NUM_FIELDS];
  logic [VAL_W-1:0] vals_d [NUM_FIELDS];
  logic [NC-1:0]    cursor_q, cursor_d;
  logic             stb_q, stb_d;
  action_e          act;
  logic [FW-1:0]    fsel;
  wide_t            stepw, stepm, cur, nxt;

  always_comb begin
    act = ACT_NONE;
    if      (pulse[3]) act = ACT_RIGHT;
    else if (pulse[2]) act = ACT_LEFT;
    else if (pulse[0]) act = ACT_UP;
    else if (pulse[1]) act = ACT_DOWN;
  end

  // Wrap mode uses the weight reduced modulo MAX_VAL+1 so a single
  // conditional correction gives the true modulo result.
  always_comb begin
    fsel  = '0;
    stepw = '0;
    stepm = '0;
    for (int unsigned i = 0; i < NC; i++) begin
      if (cursor_q[i]) begin
        fsel  = FW'(i / DIGITS_PER_FIELD);
        stepw = wide_t'(pow10(i % DIGITS_PER_FIELD));
        stepm = wide_t'(pow10(i % DIGITS_PER_FIELD) % (64'(MAX_VAL) + 64'd1));
      end
    end
    cur = {1'b0, vals_q[fsel]};
    nxt = cur;
    if (act == ACT_UP) begin
      if (VAL_WRAP) begin
        nxt = cur + stepm;
        if (nxt > MAXW) nxt = nxt - MODW;
      end else if (cur + stepw <= MAXW) begin
        nxt = cur + stepw;
      end
    end else if (act == ACT_DOWN) begin
      if (VAL_WRAP) nxt = (cur < stepm) ? cur + MODW - stepm : cur - stepm;
      else if (cur >= stepw) nxt = cur - stepw;
    end
  end

  always_comb begin
    vals_d   = vals_q;
    cursor_d = cursor_q;
    stb_d    = 1'b0;
    case (act)
      ACT_RIGHT: begin
        if (!cursor_q[0])    cursor_d = cursor_q >> 1;
        else if (CURSOR_WRAP) cursor_d = {1'b1, {(NC-1){1'b0}}};
      end
      ACT_LEFT: begin
        if (!cursor_q[NC-1]) cursor_d = cursor_q << 1;
        else if (CURSOR_WRAP) cursor_d = {{(NC-1){1'b0}}, 1'b1};
      end
      ACT_UP, ACT_DOWN: begin
        if (!lock && nxt != cur) begin
          vals_d[fsel] = nxt[VAL_W-1:0];
          stb_d        = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vals_q   <= '{default: '0};
      cursor_q <= {1'b1, {(NC-1){1'b0}}};
      stb_q    <= 1'b0;
    end else begin
      vals_q   <= vals_d;
      cursor_q <= cursor_d;
      stb_q    <= stb_d;
    end
  end

  for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_out
    assign values[f*VAL_W +: VAL_W] = vals_q[f];
  end
  assign dotpos_n = ~cursor_q;
  assign edit_stb = stb_q;

endmodule

// File: tb/tb_digit_field_editor.sv
// Randomised and directed stimulus for digit_field_editor, checked every
// cycle against a behavioural model; two instances cover both wrap modes.
module tb_digit_field_editor;

  localparam int NF = 2, DPF = 2, NC = 4, MAXV = 99, RD = 8, RP = 4;
  localparam logic [3:0] K_UP = 4'b0001, K_DN = 4'b0010, K_LT = 4'b0100, K_RT = 4'b1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, lock;
  logic [3:0]  kb;
  logic [63:0] values_a, values_b;
  logic [3:0]  dot_a, dot_b;
  logic        stb_a, stb_b;

  digit_field_editor #(.NUM_FIELDS(NF), .DIGITS_PER_FIELD(DPF), .VAL_W(32), .MAX_VAL(MAXV),
    .VAL_WRAP(1'b0), .CURSOR_WRAP(1'b0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .up(kb[0]), .down(kb[1]), .left(kb[2]), .right(kb[3]),
    .lock(lock), .values(values_a), .dotpos_n(dot_a), .edit_stb(stb_a));

  digit_field_editor #(.NUM_FIELDS(NF), .DIGITS_PER_FIELD(DPF), .VAL_W(32), .MAX_VAL(MAXV),
    .VAL_WRAP(1'b1), .CURSOR_WRAP(1'b1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .up(kb[0]), .down(kb[1]), .left(kb[2]), .right(kb[3]),
    .lock(lock), .values(values_b), .dotpos_n(dot_b), .edit_stb(stb_b));

  int n_total = 0, n_bad = 0;

  // Model: cursor as a digit index, fields as integers, keys as delay lines
  // plus a held-cycle count.
  int m_idx [2];
  int m_val [2][NF];
  bit m_stb [2];
  bit s1 [4], s2 [4], pv [4], pl [4];
  int hold [4];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_idx[m] = NC - 1;
      m_stb[m] = 1'b0;
      for (int f = 0; f < NF; f++) m_val[m][f] = 0;
    end
    for (int k = 0; k < 4; k++) begin
      s1[k] = 0; s2[k] = 0; pv[k] = 0; pl[k] = 0; hold[k] = 0;
    end
  endtask

  task automatic model_apply(input int m, input int act);
    int f, step, v, nv;
    bit wrap;
    wrap = (m == 1);
    m_stb[m] = 1'b0;
    case (act)
      3: m_idx[m] = (m_idx[m] == 0) ? (wrap ? NC - 1 : 0) : m_idx[m] - 1;
      2: m_idx[m] = (m_idx[m] == NC - 1) ? (wrap ? 0 : NC - 1) : m_idx[m] + 1;
      0, 1: begin
        f = m_idx[m] / DPF;
        step = (m_idx[m] % DPF == 0) ? 1 : 10;
        v = m_val[m][f];
        nv = (act == 0) ? v + step : v - step;
        if (nv < 0 || nv > MAXV) nv = wrap ? ((nv % (MAXV + 1)) + MAXV + 1) % (MAXV + 1) : v;
        if (!lock && nv != v) begin
          m_val[m][f] = nv;
          m_stb[m] = 1'b1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic model_step();
    int act;
    bit np;
    if (!rst_n) begin
      model_reset();
      return;
    end
    act = pl[3] ? 3 : pl[2] ? 2 : pl[0] ? 0 : pl[1] ? 1 : -1;
    for (int m = 0; m < 2; m++) model_apply(m, act);
    for (int k = 0; k < 4; k++) begin
      np = (s2[k] && !pv[k]) ||
           (RD != 0 && s2[k] && hold[k] >= RD && (hold[k] - RD) % RP == 0);
      pl[k] = np;
      hold[k] = s2[k] ? hold[k] + 1 : 0;
      pv[k] = s2[k];
      s2[k] = s1[k];
      s1[k] = kb[k];
    end
  endtask

  function automatic logic [63:0] exp_vals(input int m);
    return {32'(m_val[m][1]), 32'(m_val[m][0])};
  endfunction

  function automatic logic [3:0] exp_dot(input int m);
    return ~(4'b0001 << m_idx[m]);
  endfunction

  task automatic check_all();
    chk("values_a", values_a, exp_vals(0));
    chk("dot_a", 64'(dot_a), 64'(exp_dot(0)));
    chk("stb_a", 64'(stb_a), 64'(m_stb[0]));
    chk("values_b", values_b, exp_vals(1));
    chk("dot_b", 64'(dot_b), 64'(exp_dot(1)));
    chk("stb_b", 64'(stb_b), 64'(m_stb[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic press(input logic [3:0] k, input int hl, input int gap);
    kb = k;
    repeat (hl) tick();
    kb = '0;
    repeat (gap) tick();
  endtask

  task automatic chk_reset_consts();
    chk("rst_vals_a", values_a, 64'd0);
    chk("rst_dot_a", 64'(dot_a), 64'h7);
    chk("rst_stb_a", 64'(stb_a), 64'd0);
    chk("rst_dot_b", 64'(dot_b), 64'h7);
  endtask

  initial begin
    rst_n = 1'b0;
    kb    = '0;
    lock  = 1'b0;
    model_reset();
    @(negedge clk);
    chk_reset_consts();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    press(K_UP, 3, 6);
    chk("first_up", values_a, {32'd10, 32'd0});

    repeat (3) press(K_RT, 2, 5);
    repeat (5) press(K_UP, 2, 5);
    repeat (6) press(K_DN, 2, 5);

    repeat (3) press(K_LT, 2, 5);
    repeat (9) press(K_UP, 2, 5);

    repeat (3) press(K_RT, 2, 5);
    press(K_UP, 30, 20);

    lock = 1'b1;
    repeat (3) press(K_UP, 2, 5);
    press(K_LT, 2, 5);
    lock = 1'b0;
    repeat (3) press(K_LT, 2, 5);

    press(K_UP | K_RT, 3, 6);
    press(K_DN | K_LT, 3, 6);

    kb = K_UP;
    repeat (18) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_reset_consts();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    kb = '0;
    repeat (8) tick();

    repeat (4000) begin
      for (int k = 0; k < 4; k++) if ($urandom_range(11) == 0) kb[k] = ~kb[k];
      if ($urandom_range(199) == 0) lock = ~lock;
      if ($urandom_range(1499) == 0) begin
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
